// File: rtl/pipe_reg_pkg.sv
// Shared sizing helpers and types for the elastic pipeline register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_reg_pkg;

    // Default data width, matching the 16-bit flop this block replaces.
    localparam int DEFAULT_WIDTH = 16;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // One stage as seen at the default width: valid flag plus payload.
    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } stage_t;

endpackage

// File: rtl/pipe_reg_if.sv
// Handshake bundle for pipe_reg: input side, output side and occupancy.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry the valid/ready stall in each direction.
interface pipe_reg_if #(
    parameter int WIDTH = pipe_reg_pkg::DEFAULT_WIDTH,
    parameter int DEPTH = 2
) ();
    import pipe_reg_pkg::*;

    localparam int CW = cnt_w(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    // Environment side: produces input items, consumes output items.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    // Pipeline side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline stage: a valid bit plus a data register.
// Latency: 1 cycle from upstream to this stage when enabled.
// Backpressure: holds its contents while en_i is low; clr_i drops valid but keeps data.
module pipe_stage
    import pipe_reg_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    // Next state: clear wins; otherwise take the upstream item when enabled,
    // loading data only for a real item so the payload never picks up junk.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (en_i) begin
            vld_d = vld_i;
            if (vld_i) begin
                dat_d = dat_i;
            end
        end
    end

    // Stage registers with asynchronous reset to a known payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= 1'b0;
            dat_q <= RESET_VALUE;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/pipe_reg.sv
// Elastic DEPTH-stage pipeline register with bubble collapsing, flush and occupancy count.
// Latency: DEPTH cycles when empty (0 cycles when built with PIPE_REG_BYPASS_EN and empty).
// Backpressure: per-stage ready chain; in_ready drops only when every stage is full and out_ready is low, or on flush.
module pipe_reg
    import pipe_reg_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    pipe_reg_if.slave bus
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [DEPTH:0]   rdy;
    logic             in_xfer;
    logic             out_xfer;
    logic             s0_vld;
    logic [CW-1:0]    count_q, count_d;

    // Ready ripples from the output back: a stage can take a new item if it
    // is empty or its own item is moving on this cycle.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = ~vld[i] | rdy[i + 1];
        end
    end

    assign bus.in_ready = rdy[0] & ~flush;
    assign in_xfer      = bus.in_valid & bus.in_ready;
    assign out_xfer     = bus.out_valid & bus.out_ready;

`ifdef PIPE_REG_BYPASS_EN
    // When nothing is held, the input is visible at the output directly; an
    // item taken downstream this cycle must not also land in stage 0.
    logic byp;
    assign byp           = (count_q == '0) & ~flush;
    assign bus.out_valid = byp ? bus.in_valid : vld[DEPTH-1];
    assign bus.out_data  = (byp & bus.in_valid) ? bus.in_data : dat[DEPTH-1];
    assign s0_vld        = in_xfer & ~(byp & bus.out_ready);
`else
    assign bus.out_valid = vld[DEPTH-1];
    assign bus.out_data  = dat[DEPTH-1];
    assign s0_vld        = in_xfer;
`endif

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic             up_vld;
            logic [WIDTH-1:0] up_dat;

            if (i == 0) begin : g_head
                assign up_vld = s0_vld;
                assign up_dat = bus.in_data;
            end else begin : g_body
                assign up_vld = vld[i-1];
                assign up_dat = dat[i-1];
            end

            pipe_stage #(
                .WIDTH      (WIDTH),
                .RESET_VALUE(RESET_VALUE)
            ) u_stage (
                .clk  (clk),
                .reset(reset),
                .clr_i(flush),
                .en_i (rdy[i]),
                .vld_i(up_vld),
                .dat_i(up_dat),
                .vld_o(vld[i]),
                .dat_o(dat[i])
            );
        end
    endgenerate

    // Occupancy: flush empties; a simultaneous in and out transfer cancels.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count = count_q;

endmodule

// File: doc/pipe_reg.md
Name: pipe_reg

Overview:
- Parametrised elastic pipeline register; successor to the fixed 16-bit enable/set/reset flop.
- Generalised in width and depth, with a valid/ready handshake per stage, bubble collapsing, synchronous flush and an occupancy count.
- Sits between datapath stages (e.g. ALU result to writeback) where back-pressure must stall upstream without losing data.

Parameters:
- WIDTH, 16, data bits per stage (>=1).
- DEPTH, 2, number of register stages (>=1).
- RESET_VALUE, '0, value loaded into every data register on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  out_data holds a valid item.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  data of the output stage.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Stages are numbered 0 (input side) to DEPTH-1 (output side). Each stage holds a data register and a valid bit. out_data = data[DEPTH-1]; out_valid = valid[DEPTH-1].
- Reset (async, reset=1): all valid=0, all data=RESET_VALUE, count=0. in_ready goes high once reset deasserts (no flush pending). Reset asserted mid-transfer discards all held items.
- Ready chain (combinational):
  - rdy[DEPTH-1] = ~valid[DEPTH-1] | out_ready.
  - rdy[i] = ~valid[i] | rdy[i+1].
  - in_ready = rdy[0] & ~flush.
- Stage update on each clk edge (no flush):
  - If rdy[i]: valid[i] <= upstream valid (in_valid&in_ready for stage 0, valid[i-1] otherwise).
  - data[i] loads only when the upstream item is valid; otherwise data holds.
  - If !rdy[i]: stage holds.
- Bubble collapsing: an empty stage accepts from upstream even while the output is stalled.
- Latency: DEPTH cycles from accept to out_valid when empty. Throughput: 1 item/cycle when out_ready is held high.
- Transfers: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready.
- count: +1 on in-transfer, -1 on out-transfer, unchanged if both occur in the same cycle. Never exceeds DEPTH or wraps below 0.
- Full (count==DEPTH) with out_ready=0: in_ready=0. Full with out_ready=1: in_ready=1 and simultaneous in/out transfer is allowed.
- flush=1 at an edge: all valid <= 0, count <= 0, data unchanged. in_valid is ignored and in_ready=0 that cycle. out_valid is still driven from current state during the flush cycle, but the output item is dropped even if out_ready=1.
- No X propagation: out_data always drives a defined value (RESET_VALUE or last loaded data).

Optional Feature:
- Macro: PIPE_REG_BYPASS_EN.
- Defined: when count==0 and flush=0, in_data/in_valid route combinationally to out_data/out_valid. If out_ready=1, the item transfers with zero latency, stage 0 does not load, and count is unchanged. If out_ready=0, the item enters stage 0 normally. in_ready = rdy[0] & ~flush (unchanged).
- Undefined: no combinational in-to-out path; minimum latency is DEPTH cycles.

Decomposition:
- Package pipe_reg_pkg holds:
  - function cnt_w(depth) returning $clog2(depth+1);
  - typedef struct packed {logic valid; logic [WIDTH-1:0] data;} via a parameterised-width convention constant DEFAULT_WIDTH=16.
- Sub-module pipe_stage: one valid+data register with async reset, load enable and synchronous clear. pipe_reg instantiates DEPTH copies in a generate loop and computes the ready chain and count.

Test Plan:
- Reset: reset=1 mid-stream with 2 items held -> out_valid=0, count=0, out_data=16'h0000 immediately (async); after release in_ready=1.
- Streaming: DEPTH=2, out_ready=1, send 16'h0001..16'h0008 on consecutive cycles -> first out_valid 2 cycles after first accept, outputs in order one per cycle, count steady at 2.
- Back-pressure: out_ready=0, send 16'hA5A5, 16'h5A5A, 16'hFFFF -> first two accepted, count=2, in_ready=0 on third. Raise out_ready -> A5A5 then 5A5A out; FFFF accepted the same cycle A5A5 leaves.
- Bubble collapse: DEPTH=3, out_ready=0, one item at stage 2, stage 1 empty -> next in_valid accepted (in_ready=1), count goes 1 to 2.
- Flush: 2 items held, flush=1 with in_valid=1 data 16'h1234 -> next cycle count=0, out_valid=0, 16'h1234 never appears at the output.
- Bypass (PIPE_REG_BYPASS_EN): empty, out_ready=1, in_valid=1 data 16'hBEEF -> out_valid=1 and out_data=16'hBEEF in the same cycle, count stays 0.
